// File: rtl/axi_line_master.sv
// AXI4 burst master: turns one cache-line refill or writeback into a single INCR burst.
// Optional watchdog on stalled channels is compiled in with `define AXI_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request; completion pulse shown here
// AR    | read address presented, waiting for AR_READY
// R     | collecting read beats into the line buffer
// AW    | write address presented, waiting for AW_READY
// W     | streaming the latched line out one beat per handshake
// B     | waiting for the write response
module axi_line_master #(
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int LINE_WIDTH     = 512,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        arstn,
   input  logic                        i_start_read,
   input  logic                        i_start_write,
   input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
   input  logic [LINE_WIDTH-1:0]       i_line,
   output logic [LINE_WIDTH-1:0]       o_line,
   output logic                        o_done,
   output logic                        o_busy,
   output logic                        o_error,
   output logic                        AR_VALID,
   output logic [AXI_ADDR_WIDTH-1:0]   AR_ADDR,
   output logic [7:0]                  AR_LEN,
   output logic [2:0]                  AR_SIZE,
   output logic [1:0]                  AR_BURST,
   output logic [2:0]                  AR_PROT,
   input  logic                        AR_READY,
   input  logic [AXI_DATA_WIDTH-1:0]   R_DATA,
   input  logic [1:0]                  R_RESP,
   input  logic                        R_LAST,
   input  logic                        R_VALID,
   output logic                        R_READY,
   output logic                        AW_VALID,
   output logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
   output logic [7:0]                  AW_LEN,
   output logic [2:0]                  AW_SIZE,
   output logic [1:0]                  AW_BURST,
   output logic [2:0]                  AW_PROT,
   input  logic                        AW_READY,
   output logic [AXI_DATA_WIDTH-1:0]   W_DATA,
   output logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
   output logic                        W_LAST,
   output logic                        W_VALID,
   input  logic                        W_READY,
   input  logic [1:0]                  B_RESP,
   input  logic                        B_VALID,
   output logic                        B_READY
);

   localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
   localparam int CW    = $clog2(BEATS);
   localparam int OFF   = $clog2(LINE_WIDTH / 8);
   localparam logic [CW-1:0]             LAST_BEAT = CW'(BEATS - 1);
   localparam logic [7:0]                BURST_LEN = 8'(BEATS - 1);
   localparam logic [2:0]                BEAT_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = {{(AXI_ADDR_WIDTH-OFF){1'b1}}, {OFF{1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

   state_t                    state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0]     wline_q, wline_d;
   logic [LINE_WIDTH-1:0]     rline_q, rline_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      err_q, err_d;
   logic                      done_q, done_d;
   logic                      drain_q, drain_d;

`ifdef AXI_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] WDOG_LOAD = TW'(TIMEOUT_CYCLES);
   logic [TW-1:0] wdog_q, wdog_d;
   logic          chan_hs;

   assign chan_hs = (state_q == S_AR && AR_READY) || (state_q == S_R && R_VALID) ||
                    (state_q == S_AW && AW_READY) || (state_q == S_W && W_READY) ||
                    (state_q == S_B && B_VALID);
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wline_d  = wline_q;
      rline_d  = rline_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      done_d   = 1'b0;
      drain_d  = drain_q;
      AR_VALID = 1'b0;
      R_READY  = 1'b0;
      AW_VALID = 1'b0;
      W_VALID  = 1'b0;
      B_READY  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // write has priority; a simultaneous read is dropped and must be re-issued
            if (i_start_write) begin
               addr_d  = i_addr;
               wline_d = i_line;
               err_d   = 1'b0;
               state_d = S_AW;
            end else if (i_start_read) begin
               addr_d  = i_addr;
               err_d   = 1'b0;
               state_d = S_AR;
            end
         end
         S_AR: begin
            AR_VALID = 1'b1;
            if (AR_READY) begin
               cnt_d   = '0;
               drain_d = 1'b0;
               state_d = S_R;
            end
         end
         S_R: begin
            R_READY = 1'b1;
            if (R_VALID) begin
               if (R_RESP != 2'b00) err_d = 1'b1;
               if (drain_q) begin
                  if (R_LAST) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  rline_d[int'(cnt_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = R_DATA;
                  if (cnt_q == LAST_BEAT) begin
                     // a missing R_LAST means the slave overruns; swallow beats until it ends
                     if (R_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                     end else begin
                        err_d   = 1'b1;
                        drain_d = 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                     if (R_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                     end
                  end
               end
            end
         end
         S_AW: begin
            AW_VALID = 1'b1;
            if (AW_READY) begin
               cnt_d   = '0;
               state_d = S_W;
            end
         end
         S_W: begin
            W_VALID = 1'b1;
            if (W_READY) begin
               if (cnt_q == LAST_BEAT) state_d = S_B;
               else                    cnt_d   = cnt_q + 1'b1;
            end
         end
         S_B: begin
            B_READY = 1'b1;
            if (B_VALID) begin
               if (B_RESP != 2'b00) err_d = 1'b1;
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef AXI_TIMEOUT_EN
      wdog_d = WDOG_LOAD;
      if (state_q != S_IDLE && !chan_hs) begin
         if (wdog_q == TW'(1)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            done_d  = 1'b1;
            drain_d = 1'b0;
         end else begin
            wdog_d = wdog_q - 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wline_q <= '0;
         rline_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         drain_q <= 1'b0;
`ifdef AXI_TIMEOUT_EN
         wdog_q  <= WDOG_LOAD;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wline_q <= wline_d;
         rline_q <= rline_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         done_q  <= done_d;
         drain_q <= drain_d;
`ifdef AXI_TIMEOUT_EN
         wdog_q  <= wdog_d;
`endif
      end
   end

   assign o_line   = rline_q;
   assign o_done   = done_q;
   assign o_busy   = (state_q != S_IDLE);
   assign o_error  = err_q;

   assign AR_ADDR  = addr_q & ADDR_MASK;
   assign AR_LEN   = BURST_LEN;
   assign AR_SIZE  = BEAT_SIZE;
   assign AR_BURST = 2'b01;
   assign AR_PROT  = 3'b000;

   assign AW_ADDR  = addr_q & ADDR_MASK;
   assign AW_LEN   = BURST_LEN;
   assign AW_SIZE  = BEAT_SIZE;
   assign AW_BURST = 2'b01;
   assign AW_PROT  = 3'b000;

   assign W_DATA   = wline_q[int'(cnt_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
   assign W_STRB   = '1;
   assign W_LAST   = (state_q == S_W) && (cnt_q == LAST_BEAT);

endmodule

// File: doc/axi_line_master.md
Name: axi_line_master

Overview:
- AXI4 burst master between the cache controller and the memory-side AXI slave.
- Converts one cache-line request into one AXI burst:
  - refill: AR + R beats, assembled into a LINE_WIDTH buffer;
  - writeback: AW + W beats serialised from a LINE_WIDTH buffer, then B response.
- One transaction at a time; no outstanding or overlapping bursts.

Parameters:
AXI_ADDR_WIDTH, 64, address width of AXI and request address
AXI_DATA_WIDTH, 32, AXI data beat width (power of 2, >= 8)
LINE_WIDTH, 512, cache line width; BEATS = LINE_WIDTH/AXI_DATA_WIDTH (default 16)
TIMEOUT_CYCLES, 255, watchdog limit (used only with AXI_TIMEOUT_EN)

Ports:
clk  in  1  clock
arstn  in  1  asynchronous active-low reset
i_start_read  in  1  request line refill (sampled in IDLE only)
i_start_write  in  1  request line writeback (sampled in IDLE only)
i_addr  in  AXI_ADDR_WIDTH  line address
i_line  in  LINE_WIDTH  writeback data, captured at accept
o_line  out  LINE_WIDTH  refill data
o_done  out  1  one-cycle completion pulse
o_busy  out  1  high in every state except IDLE
o_error  out  1  sticky error, cleared on next accepted request
AR_VALID/AR_ADDR/AR_LEN[7:0]/AR_SIZE[2:0]/AR_BURST[1:0]/AR_PROT[2:0]  out; AR_READY  in
R_DATA  in  AXI_DATA_WIDTH; R_RESP[1:0]/R_LAST/R_VALID  in; R_READY  out
AW_VALID/AW_ADDR/AW_LEN/AW_SIZE/AW_BURST/AW_PROT  out; AW_READY  in
W_DATA  out  AXI_DATA_WIDTH; W_STRB  out  AXI_DATA_WIDTH/8; W_LAST/W_VALID  out; W_READY  in
B_RESP[1:0]/B_VALID  in; B_READY  out

Behaviour:
- Reset (arstn low, async): state IDLE, all VALID/READY outputs 0, o_line 0, o_done 0, o_busy 0, o_error 0, beat counter 0.
- Reset mid-burst: abort immediately, no completion pulse.
- States: IDLE, AR, R, AW, W, B.
- IDLE:
  - i_start_write -> latch i_addr and i_line, clear o_error -> AW.
  - else i_start_read -> latch i_addr, clear o_error -> AR.
  - Both high: write wins; read not latched, requester re-issues.
- Address: low log2(LINE_WIDTH/8) bits forced to 0 (line aligned).
- Constant fields:
  - LEN = BEATS-1;
  - SIZE = log2(AXI_DATA_WIDTH/8) (default 3'b010);
  - BURST = 2'b01 (INCR);
  - PROT = 3'b000;
  - W_STRB all ones.
- AR / AW:
  - VALID high the cycle after accept, held with stable address until READY.
  - Handshake cycle -> R or W; counter cleared.
- R:
  - R_READY = 1 throughout.
  - Each R_VALID handshake writes R_DATA into o_line[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH], k = counter; counter increments.
  - Handshake on k = BEATS-1 -> IDLE, o_done pulse next cycle.
  - R_LAST high with k != BEATS-1 -> o_error = 1; burst terminates -> IDLE with o_done.
  - R_LAST low at k = BEATS-1 -> o_error = 1; beat still accepted; stay in R, discarding beats until R_LAST.
  - Any R_RESP != 2'b00 -> o_error = 1; beats still stored.
- W:
  - W_VALID = 1 throughout; W_DATA = latched line slice k.
  - Slice advances only on W_READY handshake; data stable while stalled.
  - W_LAST = (k == BEATS-1).
  - Last handshake -> B.
- B:
  - B_READY = 1.
  - B handshake -> IDLE, o_done pulse.
  - B_RESP != 2'b00 -> o_error = 1.
- o_line holds its value until the next read's first beat.
- o_done: exactly one cycle, first cycle back in IDLE.
- A request may be accepted in that same cycle.
- Counter width: log2(BEATS) bits, no wrap within a burst.

Optional Feature:
- Macro AXI_TIMEOUT_EN.
- Defined:
  - Watchdog counter counts cycles in AR/R/AW/W/B without a handshake on the active channel; reset on each handshake.
  - Reaching TIMEOUT_CYCLES -> all VALID/READY drop to 0, o_error = 1, state IDLE, o_done pulse.
- Undefined: no watchdog; master waits indefinitely. Logic absent.

Test Plan:
- Read @0x1000_0047, slave returns beats 0x0000_0000..0x0000_000F, R_LAST on 16th -> AR_ADDR 0x1000_0040, AR_LEN 15, o_line[31:0]=0, o_line[511:480]=0xF, o_done one pulse, o_error 0.
- Write @0x2000_0000, i_line word k = 0xA5A5_0000+k, W_READY toggled 1/0 each cycle -> 16 W beats in order, W_LAST only on beat 15, data stable during stalls, AW_LEN 15, o_done after B (B_RESP 00).
- i_start_read and i_start_write high together in IDLE -> only AW issued, no AR until read re-requested.
- Read with R_LAST on beat 9 -> o_error 1, IDLE, o_done; next request clears o_error.
- Write with B_RESP 2'b10; separate read with R_RESP 2'b11 on beat 3 -> o_error 1 in both cases.
- arstn low during beat 7 of read -> R_READY/AR_VALID 0 immediately, o_busy 0, no o_done.
- With AXI_TIMEOUT_EN: AR_READY held 0 -> abort at TIMEOUT_CYCLES with o_error 1 and o_done.
